// File: rtl/timer_pkg.sv
// Shared types and default constants for the countdown timer block.
// Imported by timer_ctrl and tick_gen.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } timer_state_e;

    localparam int DefPrescaleMax = 25000000;
    localparam int DefTimerWidth  = 8;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: divides clk down to a one-cycle tick every PrescaleMax enabled cycles.
// Holds its count while en is low; clr forces the count back to zero.
module tick_gen
    import timer_pkg::*;
#(
    parameter int PrescaleMax = DefPrescaleMax
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CntWidth = $clog2(PrescaleMax);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(PrescaleMax - 1);

    logic [CntWidth-1:0] cnt;
    logic                at_last;

    assign at_last = (cnt == CntLast);
    assign tick    = en && at_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + CntWidth'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: IDLE/RUN/PAUSE FSM, remaining/reload registers
// and the registered expiry pulse, driven by the tick_gen prescaler.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int PrescaleMax = DefPrescaleMax,
    parameter int TimerWidth  = DefTimerWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  periodic,
    input  logic [TimerWidth-1:0] load_val,
    output logic                  busy,
    output logic                  paused,
    output logic                  expired,
    output logic [TimerWidth-1:0] remaining,
    output logic                  tick
);

    timer_state_e          state_q, state_d;
    logic [TimerWidth-1:0] remaining_d;
    logic [TimerWidth-1:0] reload_q, reload_d;
    logic                  mode_q, mode_d;
    logic                  expired_d;
    logic                  pre_en;
    logic                  pre_clr;

    tick_gen #(
        .PrescaleMax (PrescaleMax)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    assign pre_en = (state_q == ST_RUN);
    assign busy   = (state_q != ST_IDLE);
    assign paused = (state_q == ST_PAUSE);

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining;
        reload_d    = reload_q;
        mode_d      = mode_q;
        expired_d   = 1'b0;
        pre_clr     = (state_q == ST_IDLE);

        if (stop) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            pre_clr     = 1'b1;
        end else if (start) begin
            remaining_d = load_val;
            reload_d    = load_val;
            mode_d      = periodic;
            pre_clr     = 1'b1;
            // A zero load expires at once and never enters RUN.
            if (load_val == '0) begin
                state_d   = ST_IDLE;
                expired_d = 1'b1;
            end else begin
                state_d   = ST_RUN;
            end
        end else begin
            if (tick) begin
                if (remaining > TimerWidth'(1)) begin
                    remaining_d = remaining - TimerWidth'(1);
                end else if (remaining == TimerWidth'(1)) begin
                    expired_d = 1'b1;
                    if (mode_q) begin
                        remaining_d = reload_q;
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            // Pause applies after the tick; a one-shot expiry to IDLE wins.
            if (pause) begin
                if (state_q == ST_RUN && state_d == ST_RUN) begin
                    state_d = ST_PAUSE;
                end else if (state_q == ST_PAUSE) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            remaining <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state_q   <= state_d;
            remaining <= remaining_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            expired   <= expired_d;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl (PrescaleMax=4, TimerWidth=8): directed
// scenarios followed by random commands, all compared to a behavioural model.
module tb_timer_ctrl;

    localparam int PM = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          periodic = 1'b0;
    logic [TW-1:0] load_val = '0;
    logic          busy;
    logic          paused;
    logic          expired;
    logic [TW-1:0] remaining;
    logic          tick;

    timer_ctrl #(
        .PrescaleMax (PM),
        .TimerWidth  (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .periodic  (periodic),
        .load_val  (load_val),
        .busy      (busy),
        .paused    (paused),
        .expired   (expired),
        .remaining (remaining),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model: counting flags, phase within a tick period, plain ints.
    bit m_counting;
    bit m_frozen;
    bit m_expired;
    bit m_mode;
    int m_phase;
    int m_rem;
    int m_reload;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit m_tick();
        return m_counting && (m_phase == PM - 1);
    endfunction

    task automatic model_reset();
        m_counting = 0; m_frozen = 0; m_expired = 0; m_mode = 0;
        m_phase = 0; m_rem = 0; m_reload = 0;
    endtask

    task automatic model_clock(input bit s, input bit sp, input bit pa, input bit per, input int lv);
        bit tk;
        tk = m_tick();
        m_expired = 0;
        if (sp) begin
            m_counting = 0; m_frozen = 0; m_phase = 0; m_rem = 0;
        end else if (s) begin
            m_reload = lv; m_mode = per; m_phase = 0; m_rem = lv; m_frozen = 0;
            m_counting = (lv != 0);
            m_expired = (lv == 0);
        end else begin
            if (m_counting) m_phase = (m_phase + 1) % PM;
            if (tk) begin
                if (m_rem > 1) begin
                    m_rem = m_rem - 1;
                end else if (m_rem == 1) begin
                    m_expired = 1;
                    if (m_mode) m_rem = m_reload;
                    else begin m_rem = 0; m_counting = 0; end
                end
            end
            if (pa) begin
                if (m_counting) begin m_counting = 0; m_frozen = 1; end
                else if (m_frozen) begin m_frozen = 0; m_counting = 1; end
            end
        end
    endtask

    task automatic check_outputs();
        check("busy", 32'(busy), 32'(m_counting | m_frozen));
        check("paused", 32'(paused), 32'(m_frozen));
        check("expired", 32'(expired), 32'(m_expired));
        check("remaining", 32'(remaining), 32'(m_rem));
    endtask

    // One clock: drive commands, check the combinational tick, clock, check registers.
    task automatic do_cycle(input bit s, input bit sp, input bit pa, input bit per, input int lv);
        start = s; stop = sp; pause = pa; periodic = per; load_val = TW'(lv);
        check("tick", 32'(tick), 32'(m_tick()));
        @(posedge clk);
        model_clock(s, sp, pa, per, lv);
        #1;
        start = 0; stop = 0; pause = 0; periodic = 0; load_val = '0;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0);
    endtask

    task automatic run_until_expired(input int s, input int budget, output int delta);
        int n = 0;
        while (expired !== 1'b1 && n < budget) begin
            do_cycle(0, 0, 0, 0, 0);
            n++;
        end
        delta = (expired === 1'b1) ? cyc - s : -1;
    endtask

    initial begin
        int s;
        int d;
        int pulses;

        model_reset();
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_expired", 32'(expired), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One-shot load 3: first expiry 3*4+1 cycles after start.
        s = cyc;
        do_cycle(1, 0, 0, 0, 3);
        check("oneshot_busy", 32'(busy), 32'd1);
        run_until_expired(s, 40, d);
        check("oneshot_delay", 32'(d), 32'd13);
        idle(1);
        check("oneshot_idle", 32'(busy), 32'd0);
        idle(3);

        // Periodic load 2: first expiry at 9, then every 8 cycles; stop silences it.
        s = cyc;
        do_cycle(1, 0, 0, 1, 2);
        run_until_expired(s, 40, d);
        check("periodic_first", 32'(d), 32'd9);
        check("periodic_reload", 32'(remaining), 32'd2);
        for (int k = 0; k < 2; k++) begin
            s = cyc;
            idle(1);
            run_until_expired(s, 40, d);
            check("periodic_spacing", 32'(d), 32'd8);
        end
        idle(2);
        do_cycle(0, 1, 0, 0, 0);
        check("periodic_stop_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (expired === 1'b1) pulses++;
        end
        check("periodic_stop_quiet", 32'(pulses), 32'd0);

        // Pause after 5 cycles, hold 10, resume: expiry slips to 23.
        s = cyc;
        do_cycle(1, 0, 0, 0, 3);
        idle(4);
        do_cycle(0, 0, 1, 0, 0);
        check("pause_entered", 32'(paused), 32'd1);
        idle(9);
        check("pause_frozen", 32'(remaining), 32'd2);
        do_cycle(0, 0, 1, 0, 0);
        check("pause_resumed", 32'(paused), 32'd0);
        run_until_expired(s, 60, d);
        check("pause_delay", 32'(d), 32'd23);
        idle(2);

        // Start and stop together: stop wins. Then a zero load expires at once.
        do_cycle(1, 0, 0, 0, 3);
        idle(3);
        do_cycle(1, 1, 0, 0, 5);
        check("startstop_busy", 32'(busy), 32'd0);
        check("startstop_rem", 32'(remaining), 32'd0);
        do_cycle(1, 0, 0, 1, 0);
        check("zero_expired", 32'(expired), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        idle(2);

        // Stop on the final tick: no pulse.
        do_cycle(1, 0, 0, 0, 1);
        idle(3);
        check("final_tick_seen", 32'(tick), 32'd1);
        do_cycle(0, 1, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (expired === 1'b1) pulses++;
            idle(1);
        end
        check("stop_final_quiet", 32'(pulses), 32'd0);

        // Pause on a tick: decrement lands, then PAUSE.
        do_cycle(1, 0, 0, 0, 3);
        idle(3);
        do_cycle(0, 0, 1, 0, 0);
        check("pause_tick_rem", 32'(remaining), 32'd2);
        check("pause_tick_paused", 32'(paused), 32'd1);
        do_cycle(0, 0, 1, 0, 0);
        idle(2);
        do_cycle(0, 1, 0, 0, 0);

        // Asynchronous reset mid-countdown, between edges.
        do_cycle(1, 0, 0, 1, 2);
        idle(5);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_paused", 32'(paused), 32'd0);
        check("arst_expired", 32'(expired), 32'd0);
        check("arst_remaining", 32'(remaining), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (expired === 1'b1) pulses++;
        end
        check("arst_quiet", 32'(pulses), 32'd0);

        // Random command traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bit s_r, sp_r, pa_r, per_r;
            int lv_r;
            s_r   = ($urandom_range(0, 19) == 0);
            sp_r  = ($urandom_range(0, 59) == 0);
            pa_r  = ($urandom_range(0, 24) == 0);
            per_r = $urandom_range(0, 1) == 1;
            lv_r  = (s_r || $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : 0;
            do_cycle(s_r, sp_r, pa_r, per_r, lv_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter PrescaleMax, default 25000000; number of clk cycles per timer tick, legal range >= 2.
REQ-002 Parameter TimerWidth, default 8; width of load value and remaining count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle command: load load_val and begin countdown.
REQ-006 stop  input  1  single-cycle command: abort countdown and return to IDLE.
REQ-007 pause  input  1  single-cycle command: toggle between RUN and PAUSE.
REQ-008 periodic  input  1  mode, sampled on start: 1 = auto-reload on expiry, 0 = one-shot.
REQ-009 load_val  input  TimerWidth  tick count, sampled on start.
REQ-010 busy  output  1  high in RUN or PAUSE.
REQ-011 paused  output  1  high in PAUSE only.
REQ-012 expired  output  1  registered one-cycle pulse on each countdown expiry.
REQ-013 remaining  output  TimerWidth  ticks left in the current period.
REQ-014 tick  output  1  one-cycle strobe from the prescaler; asserted only in RUN.

Function
REQ-015 States: IDLE, RUN, PAUSE; encoded as a package enum.
REQ-016 Command priority per cycle: stop > start > pause; lower-priority commands in the same cycle are ignored.
REQ-017 start in any state: remaining <= load_val, reload register <= load_val, mode <= periodic, prescaler <= 0, state <= RUN next cycle.
REQ-018 start with load_val == 0: no RUN entry; expired pulses the following cycle, state stays or returns to IDLE, in either mode.
REQ-019 stop in RUN or PAUSE: state <= IDLE, prescaler <= 0, remaining <= 0, no expired pulse.
REQ-020 pause in RUN -> PAUSE; pause in PAUSE -> RUN; pause in IDLE has no effect.
REQ-021 Prescaler counts 0..PrescaleMax-1 in RUN only, holds its value in PAUSE, and clears in IDLE.
REQ-022 tick is asserted combinationally in the RUN cycle where prescaler == PrescaleMax-1; the prescaler wraps to 0 in the same edge.
REQ-023 On tick with remaining > 1: remaining decrements by 1.
REQ-024 On tick with remaining == 1, one-shot: remaining <= 0, state <= IDLE, expired = 1 in the next cycle.
REQ-025 On tick with remaining == 1, periodic: remaining <= reload, state stays RUN, expired = 1 in the next cycle.
REQ-026 The period from start to the first expired is exactly load_val*PrescaleMax + 1 cycles; periodic expiries are spaced exactly load_val*PrescaleMax cycles apart.
REQ-027 A stop or start in the same cycle as a final tick overrides the expiry: no expired pulse.
REQ-028 A pause in the same cycle as a tick: the tick's decrement or expiry takes effect, then the state enters PAUSE.
REQ-029 remaining never wraps below 0; all arithmetic is unsigned at TimerWidth bits.

Reset
REQ-030 While rst_n = 0: state = IDLE, prescaler = 0, remaining = 0, reload = 0, mode = 0, expired = 0, busy = 0, paused = 0, tick = 0.
REQ-031 Reset asserted mid-countdown aborts immediately with no expired pulse; operation resumes only on a new start after rst_n rises.

Structure
REQ-032 Package timer_pkg holds the state enum timer_state_e and default constants DefPrescaleMax = 25000000 and DefTimerWidth = 8.
REQ-033 The prescaler is a separate sub-module, tick_gen, with ports clk, rst_n, en, clr, and tick; its counter width is $clog2(PrescaleMax).
REQ-034 timer_ctrl contains the FSM, the remaining/reload registers, and the expired register; outputs have no combinational path from inputs except tick.

Verification (PrescaleMax=4, TimerWidth=8)
REQ-035 Reset, then start with load_val=3 and periodic=0 -> busy=1 next cycle; remaining goes 3, 2, 1, 0; expired pulses exactly 13 cycles after start; busy=0 thereafter.
REQ-036 start with load_val=2 and periodic=1 -> expired pulses every 8 cycles; remaining reloads to 2; after stop, busy=0 and expired never pulses.
REQ-037 load_val=3 run; pause after 5 cycles, hold 10 cycles, pause again -> remaining is frozen during PAUSE; expiry is delayed by exactly 10 cycles (23 cycles after start).
REQ-038 start and stop asserted in the same cycle while in RUN -> IDLE, remaining=0; also start with load_val=0 -> expired pulses the next cycle and busy stays 0.
REQ-039 stop coinciding with the final tick -> no expired pulse; pause coinciding with a tick -> remaining decrements and paused=1.
REQ-040 rst_n driven low mid-countdown (asynchronously, between edges) -> all outputs 0 immediately; no expired pulse after release.
